// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch front end
package fetch_pkg;

  localparam int FETCH_XLEN  = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - power-of-two FIFO of fetched {pc, instr} entries; flush beats push/pop
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  fetch_entry_t           din,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW:0]     count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      // Cleared so the head reads as zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  assign count = count_q;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, next-PC masking and fetch buffer toward decode; option FETCH_MISALIGN_CHECK_EN
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  RESET_PC   = '0,
  parameter int               IMEM_BYTES = 32,
  parameter int               DEPTH      = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_pc,
  input  logic [31:0]     imem_instr,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            fault
);

  localparam logic [XLEN-1:0] PC_MASK = XLEN'(IMEM_BYTES - 1);
  localparam int              CW      = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] redirect_target;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            fault_q;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;

  assign next_pc = (pc_q + XLEN'(INSTR_BYTES)) & PC_MASK;
  assign pop     = out_valid & out_ready;
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign push    = fetch_en & ~fault_q & ~redirect_valid & ((count < CW'(DEPTH)) | pop);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_target = redirect_pc & PC_MASK;

  always_ff @(posedge clk) begin
    if (reset)               fault_q <= 1'b0;
    else if (redirect_valid) fault_q <= |redirect_pc[1:0];
  end
`else
  assign redirect_target = redirect_pc & PC_MASK & ~XLEN'(INSTR_BYTES - 1);
  assign fault_q         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)               pc_q <= RESET_PC;
    else if (redirect_valid) pc_q <= redirect_target;
    else if (push)           pc_q <= next_pc;
  end

  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = pc_q;
    wr_entry.instr = imem_instr;
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (wr_entry),
    .count (count),
    .head  (head)
  );

  assign imem_pc   = pc_q;
  assign out_valid = (count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign fault     = fault_q;

endmodule
